lfsr_stream: RTL and testbench
==============================

// Module: lfsr_stream
// PURPOSE
//  Parametrised pseudo-random word generator; next generation of the 8-bit stepping LFSR.
//  Adds: configurable width/taps/seed, Fibonacci or Galois mode, runtime seed load,
//  all-zero lock-up recovery, output decimation and a valid/ready output stream.
//  Feeds test-pattern and priority-randomisation consumers in the datapath.
// PARAMETERS
//  WIDTH  8      state/output width, 3..32
//  TAPS   8'hE1  feedback mask (bit i set = q[i] participates)
//  SEED   8'h01  reset seed and lock-up replacement; must be non-zero
//  MODE   0      0 = Fibonacci, 1 = Galois
//  DECIM  1      LFSR steps per emitted word, 1..255
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      reset: synchronous, active-high
//  enb        in   1      run enable; low freezes stepping
//  load       in   1      load seed_in this cycle
//  seed_in    in   WIDTH  runtime seed
//  out_ready  in   1      consumer accepts out_data
//  out_valid  out  1      out_data holds a new word
//  out_data   out  WIDTH  emitted LFSR word
//  lockup     out  1      1-cycle pulse: all-zero seed replaced by SEED
//  wrap       out  1      1-cycle pulse: step returned state to last loaded seed
// BEHAVIOUR
//  - Fibonacci: fb = ^(q & TAPS); q_next = {fb, q[WIDTH-1:1]} (defaults = legacy 8-bit seq).
//  - Galois: q_next = (q >> 1) ^ (q[0] ? TAPS : 0).
//  - rst: q=SEED, seed_reg=SEED, step_cnt=0, state IDLE, out_valid=0, out_data=0,
//    lockup=0, wrap=0. rst overrides load and all other inputs.
//  - FSM IDLE/STEP/VALID. IDLE->STEP when enb. STEP->IDLE when !enb (step_cnt held).
//  - Step cycle = (STEP & enb) | (VALID & out_ready & enb). Step: q<=q_next, step_cnt++.
//  - Step with step_cnt==DECIM-1: out_data<=q_next, out_valid<=1, step_cnt<=0, ->VALID.
//  - VALID: out_data/out_valid/q stable while !out_ready. On out_ready: word consumed;
//    same cycle is a step cycle if enb (DECIM=1 gives one word per clock, stays VALID);
//    otherwise out_valid<=0 and ->STEP (enb) / IDLE (!enb).
//  - load (priority below rst): q<=seed_in, seed_reg<=seed_in, step_cnt<=0, out_valid<=0
//    (pending word discarded), ->IDLE; no step that cycle. seed_in==0: SEED used, lockup=1.
//  - Defensive: q==0 at any step (unreachable otherwise) -> q<=SEED, lockup=1.
//  - wrap=1 the cycle after a step whose q_next==seed_reg; independent of emission.
//  - All outputs registered; first word DECIM cycles after entering STEP.
// TESTING
//  1 Defaults, enb=1, out_ready=1 -> out_data 0x80,0xC0,0x60,0x30 on consecutive clocks.
//  2 DECIM=4, defaults -> first out_valid with 0x30; out_valid low on 3 of every 4 cycles.
//  3 WIDTH=4,TAPS=4'h9,SEED=1,MODE=0 -> wrap exactly every 15 steps, all 15 non-zero states.
//  4 WIDTH=4,TAPS=4'h9,SEED=1,MODE=1 -> words 0x9,0xD,0xF,0xE,0x7.
//  5 out_ready low 5 cycles in VALID -> out_valid=1, data and q frozen; resume, no skip.
//  6 load seed_in=0 -> lockup pulse, q=SEED; load 0x5A during VALID -> out_valid drops,
//    next word 0xAD; rst mid-stream -> next word 0x80 as in test 1.

Source files
------------

// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised Fibonacci/Galois LFSR word generator with decimation,
// runtime seed load, all-zero lock-up recovery and a valid/ready output stream.
module lfsr_stream #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'hE1,
    parameter logic [31:0] SEED  = 32'h01,
    parameter int unsigned MODE  = 0,
    parameter int unsigned DECIM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] L_TAPS = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_SEED = SEED[WIDTH-1:0];
    localparam logic [7:0]       L_LAST = 8'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, STEP, VALID} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q, r_seed;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] w_adv, w_nq, w_lseed;
    logic             w_zero, w_step, w_emit;

    always_comb begin
        w_adv   = (MODE != 0) ? ((r_q >> 1) ^ (r_q[0] ? L_TAPS : '0))
                              : {^(r_q & L_TAPS), r_q[WIDTH-1:1]};
        w_zero  = (r_q == '0);
        // a zero state can only arise from corruption; recover rather than stall
        w_nq    = w_zero ? L_SEED : w_adv;
        w_step  = enb & ((r_state == STEP) | ((r_state == VALID) & out_ready));
        w_emit  = (r_cnt == L_LAST);
        w_lseed = (seed_in == '0) ? L_SEED : seed_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_q       <= L_SEED;
            r_seed    <= L_SEED;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            lockup    <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            lockup <= 1'b0;
            wrap   <= 1'b0;
            if (load) begin
                r_q       <= w_lseed;
                r_seed    <= w_lseed;
                r_cnt     <= '0;
                out_valid <= 1'b0;
                r_state   <= IDLE;
                lockup    <= (seed_in == '0);
            end else if (w_step) begin
                r_q       <= w_nq;
                r_cnt     <= w_emit ? '0 : r_cnt + 1'b1;
                lockup    <= w_zero;
                wrap      <= (w_nq == r_seed);
                out_valid <= w_emit;
                r_state   <= w_emit ? VALID : STEP;
                if (w_emit)
                    out_data <= w_nq;
            end else if (r_state == VALID) begin
                // consumed while disabled: drop the word and park
                if (out_ready) begin
                    out_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            end else begin
                r_state <= enb ? STEP : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed and randomized checks of lfsr_stream across four
// parameter sets against a formula-level LFSR sequence model and word scoreboard.
module tb_lfsr_stream;
    logic       clk = 1'b0, rst = 1'b1, enb = 1'b0, load = 1'b0, out_ready = 1'b0;
    logic [7:0] seed_in = '0;
    logic       v1, v2, v3, v4, lk1, lk2, lk3, lk4, wr1, wr2, wr3, wr4;
    logic [7:0] d1, d2;
    logic [3:0] d3, d4;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    lfsr_stream u1 (.clk(clk), .rst(rst), .enb(enb), .load(load), .seed_in(seed_in),
        .out_ready(out_ready), .out_valid(v1), .out_data(d1), .lockup(lk1), .wrap(wr1));
    lfsr_stream #(.DECIM(4)) u2 (.clk(clk), .rst(rst), .enb(enb), .load(load),
        .seed_in(seed_in), .out_ready(out_ready), .out_valid(v2), .out_data(d2),
        .lockup(lk2), .wrap(wr2));
    lfsr_stream #(.WIDTH(4), .TAPS(32'h9), .SEED(32'h1), .MODE(0)) u3 (.clk(clk),
        .rst(rst), .enb(enb), .load(load), .seed_in(seed_in[3:0]), .out_ready(out_ready),
        .out_valid(v3), .out_data(d3), .lockup(lk3), .wrap(wr3));
    lfsr_stream #(.WIDTH(4), .TAPS(32'h9), .SEED(32'h1), .MODE(1)) u4 (.clk(clk),
        .rst(rst), .enb(enb), .load(load), .seed_in(seed_in[3:0]), .out_ready(out_ready),
        .out_valid(v4), .out_data(d4), .lockup(lk4), .wrap(wr4));

    function automatic logic [31:0] nxt(logic [31:0] q, int w, logic [31:0] taps, bit galois);
        logic [31:0] m;
        m = (32'h1 << w) - 1;
        q = q & m;
        return galois ? (((q >> 1) ^ (q[0] ? taps : 32'h0)) & m)
                      : ((q >> 1) | (32'(^(q & taps)) << (w - 1)));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] s8, s4f, s4g, mask, held, e1, e2;
        logic [7:0]  t1c [4];
        logic [3:0]  t4c [5];
        int          acc1, acc2;
        t1c = '{8'h80, 8'hC0, 8'h60, 8'h30};
        t4c = '{4'h9, 4'hD, 4'hF, 4'hE, 4'h7};
        tick;
        tick;
        chk("rst_valid", {v1, v2, v3, v4}, 0);
        chk("rst_data", d1, 0);
        chk("rst_lockup", {lk1, lk2, lk3, lk4}, 0);
        chk("rst_wrap", {wr1, wr2, wr3, wr4}, 0);

        rst = 1'b0; enb = 1'b1; out_ready = 1'b1;
        s8 = 1; s4f = 1; s4g = 1; mask = 0;
        tick;
        chk("idle_to_step", v1, 0);
        for (int k = 1; k <= 30; k++) begin
            tick;
            s8  = nxt(s8, 8, 32'hE1, 0);
            s4f = nxt(s4f, 4, 32'h9, 0);
            s4g = nxt(s4g, 4, 32'h9, 1);
            chk("t1_valid", v1, 1);
            chk("t1_data", d1, s8);
            if (k <= 4) chk("t1_const", d1, t1c[k-1]);
            chk("t2_valid", v2, 32'(k % 4 == 0));
            if (k % 4 == 0) chk("t2_data", d2, s8);
            if (k == 4) chk("t2_first", d2, 8'h30);
            chk("t3_wrap", wr3, 32'(k % 15 == 0));
            chk("t3_data", d3, s4f);
            if (k <= 15) mask |= 32'h1 << d3;
            chk("t4_data", d4, s4g);
            if (k <= 5) chk("t4_const", d4, t4c[k-1]);
        end
        chk("t3_states", mask, 32'hFFFE);

        held = 32'(d1);
        out_ready = 1'b0;
        repeat (5) begin
            tick;
            chk("hold_valid", v1, 1);
            chk("hold_data", d1, held);
        end
        out_ready = 1'b1;
        tick;
        chk("resume_data", d1, nxt(held, 8, 32'hE1, 0));

        load = 1'b1; seed_in = 8'h00;
        tick;
        load = 1'b0;
        chk("load0_lockup", lk1, 1);
        chk("load0_valid", v1, 0);
        tick;
        chk("lockup_pulse", lk1, 0);
        tick;
        chk("load0_word", d1, 8'h80);
        load = 1'b1; seed_in = 8'h5A;
        tick;
        load = 1'b0;
        chk("load_drop", v1, 0);
        tick;
        tick;
        chk("load_valid", v1, 1);
        chk("load_word", d1, 8'hAD);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_valid", v1, 0);
        tick;
        tick;
        chk("rst_mid_word", d1, 8'h80);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        e1 = nxt(1, 8, 32'hE1, 0);
        e2 = 1;
        repeat (4) e2 = nxt(e2, 8, 32'hE1, 0);
        acc1 = 0; acc2 = 0;
        repeat (600) begin
            enb = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) != 0;
            #1;
            if (v1) begin
                chk("rnd_d1", d1, e1);
                if (out_ready) begin
                    e1 = nxt(e1, 8, 32'hE1, 0);
                    acc1++;
                end
            end
            if (v2) begin
                chk("rnd_d2", d2, e2);
                if (out_ready) begin
                    repeat (4) e2 = nxt(e2, 8, 32'hE1, 0);
                    acc2++;
                end
            end
            tick;
        end
        chk("rnd_progress1", 32'(acc1 > 50), 1);
        chk("rnd_progress2", 32'(acc2 > 10), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
